// File: rtl/colisor_tiro.sv
// Shot resolver: per-player occupancy/hit boards, edge-triggered shot FSM, remaining-piece counts.
// Build option: define COLISOR_REPEAT_HIT_EN to report re-shots on hit cells as hits.
module colisor_tiro #(
    parameter int N_GRADE   = 9,
    parameter int MAX_PECAS = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       limpar,
    input  logic       place_valid,
    input  logic       place_jogador,
    input  logic [3:0] place_x,
    input  logic [3:0] place_y,
    input  logic       ready,
    input  logic [3:0] coord_tiroX,
    input  logic [3:0] coord_tiroY,
    input  logic       jogador,
    output logic       acertou_tiro,
    output logic       done,
    output logic       busy,
    output logic [3:0] qtd_P1,
    output logic [3:0] qtd_P2
);
    localparam int         NCELL = N_GRADE * N_GRADE;
    localparam int         IW    = $clog2(NCELL);
    localparam logic [3:0] W_N   = 4'(N_GRADE);
    localparam logic [3:0] W_MAX = 4'(MAX_PECAS);

    typedef enum logic [1:0] {IDLE, CHECK, UPDATE} state_t;

    state_t                 r_state, w_next;
    logic [1:0][NCELL-1:0]  r_ocup, r_ating;
    logic [1:0][3:0]        r_qtd;
    logic                   r_ready_q, r_jog, r_hit, r_new, r_acertou, r_done;
    logic [3:0]             r_x, r_y;

    logic                   w_start, w_def, w_sinr, w_occ, w_new, w_hit, w_pinr, w_place_ok;
    logic [IW-1:0]          w_sidx, w_pidx;

    function automatic logic f_inr(input logic [3:0] x, input logic [3:0] y);
        return (x >= 4'd1) && (x <= W_N) && (y >= 4'd1) && (y <= W_N);
    endfunction

    function automatic logic [IW-1:0] f_idx(input logic [3:0] x, input logic [3:0] y);
        int t;
        t = (int'(y) - 1) * N_GRADE + int'(x) - 1;
        return f_inr(x, y) ? IW'(t) : '0;
    endfunction

    // Shot path reads the board from latched coordinates, so a same-cycle placement is visible.
    always_comb begin
        w_def  = ~r_jog;
        w_sinr = f_inr(r_x, r_y);
        w_sidx = f_idx(r_x, r_y);
        w_occ  = w_sinr && r_ocup[w_def][w_sidx];
        w_new  = w_occ && !r_ating[w_def][w_sidx];
`ifdef COLISOR_REPEAT_HIT_EN
        w_hit  = w_occ;
`else
        w_hit  = w_new;
`endif
        w_pinr     = f_inr(place_x, place_y);
        w_pidx     = f_idx(place_x, place_y);
        w_place_ok = place_valid && (r_state == IDLE) && w_pinr &&
                     !r_ocup[place_jogador][w_pidx] && (r_qtd[place_jogador] < W_MAX);
        w_start    = (r_state == IDLE) && ready && !r_ready_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_state <= IDLE;
        else if (limpar) r_state <= IDLE;
        else             r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = CHECK;
            CHECK:   w_next = UPDATE;
            UPDATE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state != IDLE);
        done         = r_done;
        acertou_tiro = r_acertou;
        qtd_P1       = r_qtd[0];
        qtd_P2       = r_qtd[1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_ready_q <= 1'b0;
        else        r_ready_q <= ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ocup <= '0; r_ating <= '0; r_qtd <= '0;
            r_acertou <= 1'b0; r_done <= 1'b0; r_hit <= 1'b0; r_new <= 1'b0;
            r_jog <= 1'b0; r_x <= '0; r_y <= '0;
        end else if (limpar) begin
            r_ocup <= '0; r_ating <= '0; r_qtd <= '0;
            r_acertou <= 1'b0; r_done <= 1'b0; r_hit <= 1'b0; r_new <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_x <= coord_tiroX; r_y <= coord_tiroY; r_jog <= jogador;
                    end
                    if (w_place_ok) begin
                        r_ocup[place_jogador][w_pidx] <= 1'b1;
                        r_qtd[place_jogador]          <= r_qtd[place_jogador] + 4'd1;
                    end
                end
                CHECK: begin
                    r_hit <= w_hit;
                    r_new <= w_new;
                end
                UPDATE: begin
                    r_acertou <= r_hit;
                    r_done    <= 1'b1;
                    if (r_new) begin
                        r_ating[w_def][w_sidx] <= 1'b1;
                        if (r_qtd[w_def] != 4'd0) r_qtd[w_def] <= r_qtd[w_def] - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_colisor_tiro.sv
// Bench for colisor_tiro: directed vector table, corner sequences, random ops vs board model.
module tb_colisor_tiro;
`ifdef COLISOR_REPEAT_HIT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk = 1'b0, reset = 1'b0, limpar = 1'b0;
    logic       place_valid = 1'b0, place_jogador = 1'b0, ready = 1'b0, jogador = 1'b0;
    logic [3:0] place_x = '0, place_y = '0, coord_tiroX = '0, coord_tiroY = '0;
    logic       acertou_tiro, done, busy;
    logic [3:0] qtd_P1, qtd_P2;

    int n_chk = 0, n_fail = 0;

    bit m_ocup [2][16][16];
    bit m_hit  [2][16][16];
    int m_cnt  [2];

    colisor_tiro dut (
        .clk(clk), .reset(reset), .limpar(limpar),
        .place_valid(place_valid), .place_jogador(place_jogador),
        .place_x(place_x), .place_y(place_y),
        .ready(ready), .coord_tiroX(coord_tiroX), .coord_tiroY(coord_tiroY),
        .jogador(jogador), .acertou_tiro(acertou_tiro), .done(done), .busy(busy),
        .qtd_P1(qtd_P1), .qtd_P2(qtd_P2)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         shot;
        bit         j;
        logic [3:0] x, y;
        bit         hit;
        logic [3:0] q1, q2;
    } vec_t;

    function automatic vec_t mk(bit s, bit j, int x, int y, bit h, int q1, int q2);
        vec_t v;
        v.shot = s; v.j = j; v.x = 4'(x); v.y = 4'(y); v.hit = h; v.q1 = 4'(q1); v.q2 = 4'(q2);
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_cnt(input string nm, input int q1, input int q2);
        chk({nm, " qtd_P1"}, int'(qtd_P1), q1);
        chk({nm, " qtd_P2"}, int'(qtd_P2), q2);
    endtask

    // All tasks start and end right after a negedge.
    task automatic do_place(input bit j, input int x, input int y);
        place_valid = 1'b1; place_jogador = j; place_x = 4'(x); place_y = 4'(y);
        @(negedge clk);
        place_valid = 1'b0;
    endtask

    task automatic do_shot(input string nm, input bit j, input int x, input int y, input bit exp);
        ready = 1'b1; jogador = j; coord_tiroX = 4'(x); coord_tiroY = 4'(y);
        @(negedge clk);
        chk({nm, " busy@1"}, int'(busy), 1);
        chk({nm, " done@1"}, int'(done), 0);
        ready = 1'b0;
        @(negedge clk);
        chk({nm, " done@2"}, int'(done), 0);
        @(negedge clk);
        chk({nm, " done"}, int'(done), 1);
        chk({nm, " acertou"}, int'(acertou_tiro), int'(exp));
        chk({nm, " busy end"}, int'(busy), 0);
        @(negedge clk);
        chk({nm, " done 1cyc"}, int'(done), 0);
    endtask

    function automatic bit inr(int x, int y);
        return x >= 1 && x <= 9 && y >= 1 && y <= 9;
    endfunction

    task automatic model_clear();
        for (int p = 0; p < 2; p++) begin
            m_cnt[p] = 0;
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin m_ocup[p][a][b] = 0; m_hit[p][a][b] = 0; end
        end
    endtask

    task automatic pulse_limpar();
        limpar = 1'b1;
        @(negedge clk);
        limpar = 1'b0;
    endtask

    vec_t tbl [16];

    initial begin
        tbl[0]  = mk(0, 1, 3, 4, 0, 0, 1);
        tbl[1]  = mk(0, 1, 5, 5, 0, 0, 2);
        tbl[2]  = mk(1, 0, 3, 4, 1, 0, 1);
        tbl[3]  = mk(1, 0, 3, 4, REP, 0, 1);
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, 1);
        tbl[5]  = mk(1, 0, 10, 2, 0, 0, 1);
        tbl[6]  = mk(0, 1, 9, 9, 0, 0, 2);
        tbl[7]  = mk(0, 1, 10, 1, 0, 0, 2);
        tbl[8]  = mk(0, 1, 0, 5, 0, 0, 2);
        tbl[9]  = mk(0, 1, 5, 5, 0, 0, 2);
        tbl[10] = mk(1, 0, 9, 9, 1, 0, 1);
        tbl[11] = mk(1, 1, 5, 5, 0, 0, 1);
        tbl[12] = mk(0, 0, 5, 5, 0, 1, 1);
        tbl[13] = mk(1, 1, 5, 5, 1, 0, 1);
        tbl[14] = mk(1, 0, 5, 5, 1, 0, 0);
        tbl[15] = mk(1, 0, 5, 10, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("rst acertou", int'(acertou_tiro), 0);
        chk("rst done", int'(done), 0);
        chk("rst busy", int'(busy), 0);
        chk_cnt("rst", 0, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            if (tbl[i].shot) do_shot(nm, tbl[i].j, int'(tbl[i].x), int'(tbl[i].y), tbl[i].hit);
            else             do_place(tbl[i].j, int'(tbl[i].x), int'(tbl[i].y));
            chk_cnt(nm, int'(tbl[i].q1), int'(tbl[i].q2));
        end

        // P1 saturation and occupied-cell drop
        for (int k = 1; k <= 3; k++) begin
            do_place(0, k, 1);
            chk("sat q1", int'(qtd_P1), k);
        end
        do_place(0, 1, 1);
        chk("occupied q1", int'(qtd_P1), 3);
        for (int k = 4; k <= 9; k++) begin
            do_place(0, k, 1);
            chk("sat q1", int'(qtd_P1), k);
        end
        do_place(0, 1, 2);
        chk_cnt("full", 9, 0);

        // Placement and start in the same cycle: the shot sees the new piece
        place_valid = 1'b1; place_jogador = 1'b1; place_x = 4'd7; place_y = 4'd7;
        ready = 1'b1; jogador = 1'b0; coord_tiroX = 4'd7; coord_tiroY = 4'd7;
        @(negedge clk);
        place_valid = 1'b0; ready = 1'b0;
        chk("same busy", int'(busy), 1);
        chk("same q2", int'(qtd_P2), 1);
        @(negedge clk);
        @(negedge clk);
        chk("same done", int'(done), 1);
        chk("same hit", int'(acertou_tiro), 1);
        chk("same q2 after", int'(qtd_P2), 0);
        @(negedge clk);

        // Edge while busy is lost; held ready does not retrigger
        ready = 1'b1; jogador = 1'b1; coord_tiroX = 4'd2; coord_tiroY = 4'd1;
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        ready = 1'b1;
        chk("busyedge busy", int'(busy), 1);
        @(negedge clk);
        chk("busyedge done", int'(done), 1);
        chk("busyedge hit", int'(acertou_tiro), 1);
        chk("busyedge q1", int'(qtd_P1), 8);
        @(negedge clk);
        chk("busyedge no retrig busy", int'(busy), 0);
        chk("busyedge done once", int'(done), 0);
        @(negedge clk);
        chk("held ready busy", int'(busy), 0);
        ready = 1'b0;
        @(negedge clk);

        // limpar during CHECK aborts the shot
        ready = 1'b1; jogador = 1'b1; coord_tiroX = 4'd3; coord_tiroY = 4'd1;
        @(negedge clk);
        chk("limpar pre busy", int'(busy), 1);
        limpar = 1'b1; ready = 1'b0;
        @(negedge clk);
        limpar = 1'b0;
        chk("limpar busy", int'(busy), 0);
        chk("limpar done", int'(done), 0);
        chk("limpar acertou", int'(acertou_tiro), 0);
        chk_cnt("limpar", 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("limpar no done", int'(done) | int'(busy), 0);
        end

        // Reset mid-shot
        do_place(1, 1, 1);
        chk("rm q2", int'(qtd_P2), 1);
        ready = 1'b1; jogador = 1'b0; coord_tiroX = 4'd1; coord_tiroY = 4'd1;
        @(negedge clk);
        ready = 1'b0; reset = 1'b0;
        #1;
        chk("rm busy", int'(busy), 0);
        chk("rm q2 cleared", int'(qtd_P2), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rm no done", int'(done), 0);
        end

        // Random ops against board model
        model_clear();
        for (int it = 0; it < 300; it++) begin
            int x, y, op;
            bit j;
            op = int'($urandom_range(0, 39));
            j  = 1'($urandom_range(0, 1));
            x  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 4));
            y  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 4));
            if (op == 0) begin
                pulse_limpar();
                model_clear();
            end else if (op < 20) begin
                if (inr(x, y) && !m_ocup[j][x][y] && m_cnt[j] < 9) begin
                    m_ocup[j][x][y] = 1;
                    m_cnt[j]++;
                end
                do_place(j, x, y);
            end else begin
                int d;
                bit exp;
                d = j ? 0 : 1;
                exp = 0;
                if (inr(x, y) && m_ocup[d][x][y]) begin
                    if (!m_hit[d][x][y]) begin
                        m_hit[d][x][y] = 1;
                        if (m_cnt[d] > 0) m_cnt[d]--;
                        exp = 1;
                    end else exp = REP;
                end
                do_shot("rnd shot", j, x, y, exp);
            end
            chk_cnt("rnd", m_cnt[0], m_cnt[1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
